// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that runs a simple dual-port RAM as a show-ahead circular FIFO.
// The read address is presented one cycle early so q always shows the head entry.
module fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = 6,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  do_wr, do_rd;

   always_comb begin
      full         = (cnt_q == DepthCnt);
      empty        = (cnt_q == '0);
      almost_full  = (cnt_q >= AfCnt);
      almost_empty = (cnt_q <= AeCnt);
      count        = cnt_q;
      overflow     = ovf_q;
      underflow    = unf_q;
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts wr&rd.
   always_comb begin
      do_wr = wr & (~full | rd) & ~flush;
      do_rd = rd & ~empty & ~flush;
   end

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      cnt_d   = cnt_q;
      if (flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         cnt_d   = '0;
      end else begin
         if (do_wr) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
         if (do_rd) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Error set beats a simultaneous clear; requests are ignored during flush.
   always_comb begin
      ovf_d = (ovf_q & ~err_clr) | (wr & full & ~rd & ~flush);
      unf_d = (unf_q & ~err_clr) | (rd & empty & ~flush);
   end

   always_comb begin
      we     = do_wr & ~reset;
      w_addr = w_ptr_q;
      r_addr = r_ptr_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: models the attached RAM and checks against a queue-based FIFO model.
module tb_fifo_ctrl;

   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset, wr, rd, flush, err_clr;
   logic [7:0]    din;
   logic          we, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [AW-1:0] w_addr, r_addr;
   logic [AW:0]   count;

   fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .flush        (flush),
      .err_clr      (err_clr),
      .we           (we),
      .w_addr       (w_addr),
      .r_addr       (r_addr),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // RAM with registered read address, write-then-read at the edge
   logic [7:0]    ram [DEPTH];
   logic [AW-1:0] r_addr_q;
   logic [7:0]    q;
   always @(posedge clk) begin
      if (we) ram[w_addr] <= din;
      r_addr_q <= r_addr;
   end
   assign q = ram[r_addr_q];

   // Reference model
   logic [7:0] mq[$];
   bit         m_ovf, m_unf;
   int         wtot, rtot;
   int         vectors, miscompares;

   task automatic model_clear();
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      wtot  = 0;
      rtot  = 0;
   endtask

   task automatic set_in(input bit w, input bit r, input bit f, input bit ec, input [7:0] dv);
      wr = w; rd = r; flush = f; err_clr = ec; din = dv;
   endtask

   task automatic tick();
      bit push_ok, pop_ok;
      @(posedge clk);
      if (err_clr) begin
         m_ovf = 0;
         m_unf = 0;
      end
      if (flush) begin
         mq.delete();
         wtot = 0;
         rtot = 0;
      end else begin
         push_ok = wr && (mq.size() < DEPTH || rd);
         pop_ok  = rd && mq.size() != 0;
         if (wr && mq.size() == DEPTH && !rd) m_ovf = 1;
         if (rd && mq.size() == 0) m_unf = 1;
         if (pop_ok) begin
            void'(mq.pop_front());
            rtot++;
         end
         if (push_ok) begin
            mq.push_back(din);
            wtot++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0, 8'h00);
      reset = 1'b1;
      model_clear();
      #3;
      vectors++;
      if ({empty, full, almost_empty, almost_full, we, count, overflow, underflow}
          !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got e=%b f=%b ae=%b af=%b we=%b cnt=%0d ovf=%b unf=%b",
                  empty, full, almost_empty, almost_full, we, count, overflow, underflow);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         set_in(1, 0, 0, 0, 8'(8'h11 * (i + 1)));
         #4;
         vectors++;
         if (we !== 1'b1 || w_addr !== AW'(i)) begin
            miscompares++;
            $display("FAIL fill_we: got we=%b w_addr=%0d want 1/%0d", we, w_addr, i);
         end
         tick();
         vectors++;
         if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || full !== (i == 7)) begin
            miscompares++;
            $display("FAIL fill_count: got cnt=%0d af=%b f=%b want %0d/%b/%b",
                     count, almost_full, full, i + 1, (i + 1 >= 6), (i == 7));
         end
      end
      vectors++;
      if (w_addr !== '0 || q !== 8'h11) begin
         miscompares++;
         $display("FAIL fill_wrap: got w_addr=%0d q=%h want 0/11", w_addr, q);
      end
   endtask

   task automatic test_overflow();
      set_in(1, 0, 0, 0, 8'h99);
      #4;
      vectors++;
      if (we !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_we: got we=%b want 0", we);
      end
      tick();
      vectors++;
      if (count !== 4'd8 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set: got cnt=%0d ovf=%b want 8/1", count, overflow);
      end
      set_in(0, 0, 0, 1, 8'h00);
      tick();
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clr: got ovf=%b want 0", overflow);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q !== 8'(8'h11 * (i + 1))) begin
            miscompares++;
            $display("FAIL drain_q[%0d]: got %h want %h", i, q, 8'(8'h11 * (i + 1)));
         end
         set_in(0, 1, 0, 0, 8'h00);
         tick();
      end
      vectors++;
      if (empty !== 1'b1 || count !== 4'd0) begin
         miscompares++;
         $display("FAIL drain_empty: got e=%b cnt=%0d want 1/0", empty, count);
      end
      set_in(0, 1, 0, 0, 8'h00);
      #4;
      vectors++;
      if (r_addr !== '0) begin
         miscompares++;
         $display("FAIL unf_raddr: got r_addr=%0d want 0", r_addr);
      end
      tick();
      vectors++;
      if (underflow !== 1'b1 || r_addr !== '0 || count !== 4'd0) begin
         miscompares++;
         $display("FAIL unf_set: got unf=%b r_addr=%0d cnt=%0d want 1/0/0",
                  underflow, r_addr, count);
      end
      set_in(0, 0, 0, 1, 8'h00);
      tick();
   endtask

   task automatic test_empty_wr_rd();
      set_in(1, 1, 0, 0, 8'h5A);
      #4;
      vectors++;
      if (we !== 1'b1) begin
         miscompares++;
         $display("FAIL ewr_we: got we=%b want 1", we);
      end
      tick();
      vectors++;
      if (count !== 4'd1 || q !== 8'h5A || underflow !== 1'b1 || empty !== 1'b0) begin
         miscompares++;
         $display("FAIL ewr_result: got cnt=%0d q=%h unf=%b e=%b want 1/5a/1/0",
                  count, q, underflow, empty);
      end
      set_in(0, 0, 0, 1, 8'h00);
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) begin
         set_in(1, 0, 0, 0, 8'(8'h60 + i));
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (q !== mq[0]) begin
            miscompares++;
            $display("FAIL b2b_q[%0d]: got %h want %h", i, q, mq[0]);
         end
         set_in(1, 1, 0, 0, 8'(8'hA0 + i));
         tick();
         vectors++;
         if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_flags[%0d]: got cnt=%0d f=%b ovf=%b unf=%b want 8/1/0/0",
                     i, count, full, overflow, underflow);
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, 0, 0, 8'h00);
         tick();
      end
      vectors++;
      if (count !== 4'd4) begin
         miscompares++;
         $display("FAIL flush_pre: got cnt=%0d want 4", count);
      end
      set_in(1, 1, 1, 0, 8'hEE);
      #4;
      vectors++;
      if (we !== 1'b0 || r_addr !== '0) begin
         miscompares++;
         $display("FAIL flush_comb: got we=%b r_addr=%0d want 0/0", we, r_addr);
      end
      tick();
      vectors++;
      if (count !== 4'd0 || empty !== 1'b1 || w_addr !== '0) begin
         miscompares++;
         $display("FAIL flush_result: got cnt=%0d e=%b w_addr=%0d want 0/1/0",
                  count, empty, w_addr);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 0, 8'(8'hC0 + i));
         tick();
      end
      set_in(1, 0, 0, 0, 8'hC3);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      vectors++;
      if ({count, empty, full, almost_empty, almost_full, we}
          !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset: got cnt=%0d e=%b f=%b ae=%b af=%b we=%b",
                  count, empty, full, almost_empty, almost_full, we);
      end
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 0, 0, 0, 8'h00);
      tick();
   endtask

   task automatic test_random();
      bit         p_ok, r_ok;
      logic [AW-1:0] e_wa, e_ra;
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), 8'($urandom));
         p_ok = !flush && wr && (mq.size() < DEPTH || rd);
         r_ok = !flush && rd && mq.size() != 0;
         e_wa = AW'(wtot % DEPTH);
         e_ra = flush ? '0 : AW'((rtot + int'(r_ok)) % DEPTH);
         #4;
         vectors++;
         if (we !== p_ok || w_addr !== e_wa || r_addr !== e_ra) begin
            miscompares++;
            $display("FAIL rand_comb[%0d]: got we=%b wa=%0d ra=%0d want %b/%0d/%0d",
                     n, we, w_addr, r_addr, p_ok, e_wa, e_ra);
         end
         tick();
         vectors++;
         if (count !== 4'(mq.size())
             || {full, empty, almost_full, almost_empty, overflow, underflow}
                !== {mq.size() == DEPTH, mq.size() == 0, mq.size() >= 6, mq.size() <= 2,
                     m_ovf, m_unf}) begin
            miscompares++;
            $display("FAIL rand_state[%0d]: got cnt=%0d f=%b e=%b af=%b ae=%b o=%b u=%b want cnt=%0d o=%b u=%b",
                     n, count, full, empty, almost_full, almost_empty, overflow, underflow,
                     mq.size(), m_ovf, m_unf);
         end
         if (mq.size() != 0) begin
            vectors++;
            if (q !== mq[0]) begin
               miscompares++;
               $display("FAIL rand_q[%0d]: got %h want %h", n, q, mq[0]);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_empty_wr_rd();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that sequences the simple dual-port RAM (one write port, registered read address) as a circular FIFO.
- Generates the RAM write enable, write address and read address from push/pop requests.
- Tracks occupancy and raises full/empty/almost flags plus sticky overflow/underflow error bits.
- Sits between the producer/consumer handshakes and the RAM instance inside the FIFO top level. Read data comes straight from the RAM q output in show-ahead (first-word-fall-through) form.

Parameters:
- ADDR_WIDTH, 3: RAM address width; FIFO depth = 2**ADDR_WIDTH.
- AF_LEVEL, 6: almost_full asserts when count >= AF_LEVEL. Legal range 1..2**ADDR_WIDTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Legal range 0..2**ADDR_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  push request; data is presented to the RAM d port by the top level in the same cycle.
- rd  input  1  pop request; the consumer has sampled q this cycle.
- flush  input  1  synchronous clear of pointers and count.
- err_clr  input  1  synchronous clear of sticky error bits.
- we  output  1  RAM write enable.
- w_addr  output  ADDR_WIDTH  RAM write address.
- r_addr  output  ADDR_WIDTH  RAM read address (the RAM registers it internally).
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_WIDTH+1  current occupancy.
- overflow  output  1  sticky: a push was attempted while full without a pop.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Registers: w_ptr, r_ptr (ADDR_WIDTH bits, wrap modulo depth), cnt (ADDR_WIDTH+1 bits), ovf, unf.
- Reset (async, reset=1): w_ptr=0, r_ptr=0, cnt=0, ovf=0, unf=0. Resulting outputs: empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0, we=0, count=0.
- Effective handshakes:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
  - When empty with wr&rd both high: do_wr=1, do_rd=0, unf sets.
  - When full with wr&rd both high: both proceed and count is unchanged.
- Outputs:
  - we = do_wr; w_addr = w_ptr (combinational).
  - r_addr = r_ptr_next, where r_ptr_next = r_ptr+1 if do_rd, else r_ptr. Because the RAM registers its read address, q equals ram[r_ptr] (the head entry) in every cycle after the edge. This gives zero-wait show-ahead.
- Write into an empty FIFO: data written at edge N is visible on q and empty=0 after edge N. Same-cycle write and read address collision is covered by RAM write-then-read at the edge.
- Pointer update on the clock edge:
  - w_ptr += do_wr; r_ptr += do_rd.
  - cnt += do_wr - do_rd.
  - Wrap from 2**ADDR_WIDTH-1 to 0 happens naturally by truncation.
- Flags are combinational decodes of cnt, so they are valid in the same cycle as count.
- Errors:
  - ovf sets on wr & full & ~rd.
  - unf sets on rd & empty.
  - Both bits hold until err_clr or reset.
  - If err_clr and a new error event occur in the same cycle, the set wins.
- flush=1: at the next edge w_ptr=r_ptr=cnt=0; wr/rd are ignored that cycle, we=0, and r_addr=0. Error bits are unaffected by flush.
- Reset asserted mid-transfer: all state clears immediately regardless of clk. A write in flight is dropped (we is forced to 0 while reset=1).
- Priority: reset > flush > push/pop.

Test Plan:
- Reset, then 8 pushes of 0x11..0x88 -> count steps 1..8, almost_full asserts at count=6, full=1 after the 8th push, w_ptr wraps to 0.
- From full, push 0x99 with rd=0 -> we=0, count stays 8, overflow=1. Pulse err_clr -> overflow=0.
- From full, 8 pops -> q shows 0x11..0x88 in order with no bubble, empty=1 at the end. One extra pop -> underflow=1, r_ptr unchanged.
- From empty, wr&rd together with d=0x5A -> only the write occurs, count=1, q=0x5A the next cycle, underflow=1.
- At count=8, 20 cycles of simultaneous wr&rd with an incrementing pattern -> count stays 8, full stays 1, FIFO ordering is preserved across pointer wraparound, no error flags.
- At count=4, assert flush -> count=0 and empty=1 after one edge. Then assert reset asynchronously during a push burst -> outputs return to reset values before the next edge.
